// File: rtl/instr_memory_pkg.sv
// Shared constants and the default program image for the instruction memory.
package riscv_imem_pkg;

  localparam int unsigned IMEM_DEPTH = 64;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0013;

  // Number of leading words in the default image that are not NOP fill.
  localparam int unsigned IMAGE_LEN  = 11;

  localparam logic [31:0] INSTR_ADD_X5   = 32'h0053_02b3;
  localparam logic [31:0] INSTR_ADDI_X5  = 32'h0051_0293;
  localparam logic [31:0] INSTR_LW_X5    = 32'h0000_a283;
  localparam logic [31:0] INSTR_SW_X5    = 32'h0050_a223;
  localparam logic [31:0] INSTR_BEQ_X5   = 32'h0052_8463;
  localparam logic [31:0] INSTR_NOP_5    = 32'h0000_0013;
  localparam logic [31:0] INSTR_JAL_X1   = 32'h0080_00ef;
  localparam logic [31:0] INSTR_NOP_7    = 32'h0000_0013;
  localparam logic [31:0] INSTR_JALR_X1  = 32'h0000_80e7;
  localparam logic [31:0] INSTR_LUI_X5   = 32'h0000_52b7;
  localparam logic [31:0] INSTR_AUIPC_X5 = 32'h0000_5297;

  // Image word for a given word index; anything past the program is NOP fill.
  function automatic logic [31:0] default_image(input int unsigned idx);
    logic [31:0] w;
    case (idx)
      0:       w = INSTR_ADD_X5;
      1:       w = INSTR_ADDI_X5;
      2:       w = INSTR_LW_X5;
      3:       w = INSTR_SW_X5;
      4:       w = INSTR_BEQ_X5;
      5:       w = INSTR_NOP_5;
      6:       w = INSTR_JAL_X1;
      7:       w = INSTR_NOP_7;
      8:       w = INSTR_JALR_X1;
      9:       w = INSTR_LUI_X5;
      10:      w = INSTR_AUIPC_X5;
      default: w = NOP_WORD;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_memory_fault_chk.sv
// Combinational fetch-address checker: alignment and range of a byte address.
module imem_fault_chk
  import riscv_imem_pkg::*;
#(
  parameter int unsigned DEPTH = IMEM_DEPTH
) (
  input  logic [31:0] addr,
  output logic        misaligned,
  output logic        out_of_range
);

  // Range compare is widened so the byte span cannot wrap for large depths.
  always_comb begin
    misaligned   = (addr[1:0] != 2'b00);
    out_of_range = (64'(addr) >= (64'(DEPTH) * 64'd4));
  end

endmodule

// File: rtl/instr_memory.sv
// Word-addressed instruction memory with combinational read and sticky fault flag.
// Optional program-load port enabled by defining IMEM_PROG_PORT_EN.
module instr_memory
  import riscv_imem_pkg::IMEM_DEPTH;
  import riscv_imem_pkg::IMAGE_LEN;
  import riscv_imem_pkg::default_image;
#(
  parameter int unsigned DEPTH    = IMEM_DEPTH,
  parameter logic [31:0] NOP_WORD = riscv_imem_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  output logic [31:0] data,
  output logic        misaligned,
  output logic        out_of_range,
  output logic        fault_sticky
`ifdef IMEM_PROG_PORT_EN
  ,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_wdata
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0] idx;
  logic [31:0]   image_word;

  assign idx = addr[AW+1:2];

  imem_fault_chk #(
    .DEPTH (DEPTH)
  ) u_fault_chk (
    .addr         (addr),
    .misaligned   (misaligned),
    .out_of_range (out_of_range)
  );

  // Default image word at the fetch index, with the module's own fill word.
  always_comb begin
    image_word = NOP_WORD;
    if (32'(idx) < IMAGE_LEN) begin
      image_word = default_image(32'(idx));
    end
  end

`ifdef IMEM_PROG_PORT_EN
  // Storage is an overlay on the constant image: a per-word valid bit selects
  // the programmed word, so clearing the bits reloads the whole default image
  // in one edge and the power-up state already reads as the image.
  logic [DEPTH-1:0] written = '0;
  logic [31:0]      mem [DEPTH];
  logic [AW-1:0]    prog_idx;
  logic             prog_ok;

  always_comb begin
    prog_idx = prog_addr[AW+1:2];
    prog_ok  = (prog_addr[1:0] == 2'b00) &&
               (64'(prog_addr) < (64'(DEPTH) * 64'd4));
  end

  // Program-port write; reset wins and restores the default image.
  always_ff @(posedge clk) begin
    if (rst) begin
      written <= '0;
    end else if (prog_we && prog_ok) begin
      written[prog_idx] <= 1'b1;
      mem[prog_idx]     <= prog_wdata;
    end
  end

  // Combinational read: programmed word if present, else image, NOP when out of range.
  always_comb begin
    data = NOP_WORD;
    if (!out_of_range) begin
      data = written[idx] ? mem[idx] : image_word;
    end
  end
`else
  // Combinational read from the constant image; NOP when out of range.
  always_comb begin
    data = NOP_WORD;
    if (!out_of_range) begin
      data = image_word;
    end
  end
`endif

  // Sticky fault flag accumulates any faulting fetch until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_sticky <= 1'b0;
    end else begin
      fault_sticky <= fault_sticky | misaligned | out_of_range;
    end
  end

endmodule

// File: tb/tb_instr_memory.sv
// Self-checking bench for instr_memory; program-port steps run when IMEM_PROG_PORT_EN is defined.
module tb_instr_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] data;
  logic        misaligned;
  logic        out_of_range;
  logic        fault_sticky;
`ifdef IMEM_PROG_PORT_EN
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_wdata;
`endif

  instr_memory #(
    .DEPTH    (64),
    .NOP_WORD (32'h0000_0013)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .addr         (addr),
    .data         (data),
    .misaligned   (misaligned),
    .out_of_range (out_of_range),
    .fault_sticky (fault_sticky)
`ifdef IMEM_PROG_PORT_EN
    ,
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_wdata   (prog_wdata)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        m;
    logic        o;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [64];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic load_model();
    for (int i = 0; i < 64; i++) model[i] = 32'h0000_0013;
    model[0]  = 32'h005302b3;
    model[1]  = 32'h00510293;
    model[2]  = 32'h0000a283;
    model[3]  = 32'h0050a223;
    model[4]  = 32'h00528463;
    model[5]  = 32'h00000013;
    model[6]  = 32'h008000ef;
    model[7]  = 32'h00000013;
    model[8]  = 32'h000080e7;
    model[9]  = 32'h000052b7;
    model[10] = 32'h00005297;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a fetch address, queue the model's prediction, then compare.
  task automatic fetch(input logic [31:0] a);
    exp_t e;
    logic [5:0] wi;
    addr = a;
    wi   = a[7:2];
    e.a  = a;
    e.m  = (a[1:0] != 2'b00);
    e.o  = (a >= 32'h100);
    e.d  = e.o ? 32'h0000_0013 : model[wi];
    sb.push_back(e);
    #2;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk($sformatf("data@%h", e.a), data, e.d);
      chk($sformatf("misaligned@%h", e.a), {31'd0, misaligned}, {31'd0, e.m});
      chk($sformatf("out_of_range@%h", e.a), {31'd0, out_of_range}, {31'd0, e.o});
    end
  endtask

  initial begin
    logic [31:0] sweep [9];
    sweep = '{32'h0, 32'h4, 32'h8, 32'h10, 32'h18, 32'h20, 32'h28, 32'h2C, 32'hFC};

    load_model();
    rst  = 1'b1;
    addr = '0;
`ifdef IMEM_PROG_PORT_EN
    prog_we    = 1'b0;
    prog_addr  = '0;
    prog_wdata = '0;
`endif
    tick();
    tick();
    rst = 1'b0;
    chk("sticky_after_reset", {31'd0, fault_sticky}, 32'd0);

    foreach (sweep[i]) fetch(sweep[i]);
    tick();
    chk("sticky_clean_sweep", {31'd0, fault_sticky}, 32'd0);

    // Out-of-range fetch sets the sticky flag, which survives a good fetch.
    fetch(32'h100);
    tick();
    chk("sticky_oor", {31'd0, fault_sticky}, 32'd1);
    fetch(32'h0);
    tick();
    chk("sticky_holds", {31'd0, fault_sticky}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("sticky_rst_clear", {31'd0, fault_sticky}, 32'd0);

    // Misaligned fetch drops low bits and sets the sticky flag.
    fetch(32'h6);
    chk("sticky_before_edge", {31'd0, fault_sticky}, 32'd0);
    tick();
    chk("sticky_misaligned", {31'd0, fault_sticky}, 32'd1);
    fetch(32'hFFFF_FFF0);
    rst = 1'b1;
    addr = 32'h0;
    tick();
    rst = 1'b0;
    chk("sticky_rst_clear2", {31'd0, fault_sticky}, 32'd0);

`ifdef IMEM_PROG_PORT_EN
    // Write, with same-cycle read still seeing the old word.
    prog_we    = 1'b1;
    prog_addr  = 32'h8;
    prog_wdata = 32'hDEAD_BEEF;
    fetch(32'h8);
    tick();
    prog_we  = 1'b0;
    model[2] = 32'hDEAD_BEEF;
    fetch(32'h8);

    // Misaligned and out-of-range writes are dropped.
    prog_we    = 1'b1;
    prog_addr  = 32'h9;
    prog_wdata = 32'h1111_1111;
    tick();
    prog_addr  = 32'h200;
    prog_wdata = 32'h2222_2222;
    tick();
    prog_we = 1'b0;
    fetch(32'h8);
    fetch(32'h0);

    // Reset restores the default image.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    load_model();
    fetch(32'h8);

    // Reset beats a simultaneous write.
    rst        = 1'b1;
    prog_we    = 1'b1;
    prog_addr  = 32'h10;
    prog_wdata = 32'hCAFE_F00D;
    tick();
    rst     = 1'b0;
    prog_we = 1'b0;
    fetch(32'h10);
    chk("sticky_prog_clean", {31'd0, fault_sticky}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
